// File: rtl/peripheral_spram_ahb3_ws.sv
// peripheral_spram_ahb3_ws: AHB3-Lite single-port RAM slave with configurable read wait states.
// Optional per-byte even parity storage and read check via PERIPHERAL_SPRAM_AHB3_PARITY_EN.
module peripheral_spram_ahb3_ws #(
    parameter int PLEN        = 16,
    parameter int XLEN        = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);
    localparam int NB  = XLEN / 8;
    localparam int OW  = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int CW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int AW1 = PLEN + 1;
    localparam logic [PLEN:0] LIMIT = AW1'(MEM_DEPTH * NB);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t r_state, w_next, w_go;
    logic [XLEN-1:0] r_mem [MEM_DEPTH];
    logic [OW+IW-1:0] r_addr;
    logic [2:0] r_size;
    logic [CW-1:0] r_cnt;
    logic r_dp_rd, r_dp_wr, r_wb_vld;
    logic [IW-1:0] r_wb_idx;
    logic [NB-1:0] r_wb_be;
    logic [XLEN-1:0] r_wb_data;
    logic w_accept, w_illegal, w_fwd, w_rd_cycle, w_perr, w_perr_hit, w_unused;
    logic [IW-1:0] w_ridx;
    logic [XLEN-1:0] w_rdata;

    function automatic logic [NB-1:0] be_of(input logic [2:0] size, input logic [OW-1:0] off);
        be_of = NB'(((1 << (1 << size)) - 1) << off);
    endfunction

    assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
    assign w_accept   = HSEL & HREADY & HTRANS[1];
    assign w_illegal  = (HSIZE > 3'(OW)) | (|(HADDR[OW-1:0] & OW'((1 << HSIZE) - 1)))
                      | ({1'b0, HADDR} >= LIMIT);
    assign w_ridx     = r_addr[OW +: IW];
    assign w_fwd      = r_wb_vld & (r_wb_idx == w_ridx);
    assign w_rd_cycle = r_dp_rd & (r_state == IDLE);
    assign w_perr_hit = w_rd_cycle & w_perr;

    // A write captured last cycle has not reached the array yet, so merge its bytes.
    always_comb begin
        w_rdata = r_mem[w_ridx];
        for (int b = 0; b < NB; b++)
            if (w_fwd && r_wb_be[b]) w_rdata[8*b +: 8] = r_wb_data[8*b +: 8];
    end

`ifdef PERIPHERAL_SPRAM_AHB3_PARITY_EN
    logic [NB-1:0] r_par [MEM_DEPTH];
    logic [NB-1:0] w_rbe;
    assign w_rbe = be_of(r_size, r_addr[OW-1:0]);
    always_comb begin
        w_perr = 1'b0;
        for (int b = 0; b < NB; b++)
            if (w_rbe[b] && !(w_fwd && r_wb_be[b]) && ((^r_mem[w_ridx][8*b +: 8]) != r_par[w_ridx][b]))
                w_perr = 1'b1;
    end
    always_ff @(posedge HCLK) begin
        if (r_wb_vld && !HRESET)
            for (int b = 0; b < NB; b++)
                if (r_wb_be[b]) r_par[r_wb_idx][b] <= ^r_wb_data[8*b +: 8];
    end
`else
    assign w_perr = 1'b0;
`endif

    assign w_go   = !w_accept ? IDLE : w_illegal ? ERR1 : (!HWRITE && WAIT_STATES > 0) ? WAIT : IDLE;
    assign w_next = (r_state == WAIT) ? ((r_cnt == CW'(WAIT_STATES - 1)) ? IDLE : WAIT)
                  : (r_state == ERR1) ? ERR2
                  : w_perr_hit ? ERR2 : w_go;

    assign HREADYOUT = HRESET | ~((r_state == WAIT) | (r_state == ERR1) | w_perr_hit);
    assign HRESP     = ~HRESET & ((r_state == ERR1) | (r_state == ERR2) | w_perr_hit);
    assign HRDATA    = (!HRESET && w_rd_cycle) ? w_rdata : '0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dp_rd  <= 1'b0;
            r_dp_wr  <= 1'b0;
            r_wb_vld <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            r_wb_vld <= r_dp_wr & HREADY;
            if (HREADY) begin
                r_dp_rd <= w_accept & ~HWRITE & ~w_illegal;
                r_dp_wr <= w_accept & HWRITE & ~w_illegal;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_addr <= HADDR[OW+IW-1:0];
            r_size <= HSIZE;
        end
        if (r_dp_wr && HREADY) begin
            r_wb_idx  <= r_addr[OW +: IW];
            r_wb_be   <= be_of(r_size, r_addr[OW-1:0]);
            r_wb_data <= HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (r_wb_vld && !HRESET)
            for (int b = 0; b < NB; b++)
                if (r_wb_be[b]) r_mem[r_wb_idx][8*b +: 8] <= r_wb_data[8*b +: 8];
    end
endmodule

// File: tb/tb_peripheral_spram_ahb3_ws.sv
// tb_peripheral_spram_ahb3_ws: pipelined AHB driver against a byte-array model,
// one instance with 0 wait states and one with 3; parity scenario when PERIPHERAL_SPRAM_AHB3_PARITY_EN is set.
module tb_peripheral_spram_ahb3_ws;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hsel [2];
    logic [15:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic hwrite [2];
    logic [2:0] hsize [2];
    logic [1:0] htrans [2];
    logic hreadyout [2];
    logic hresp [2];

    int checks = 0;
    int fails = 0;
    int ws [2] = '{0, 3};
    logic [7:0] mm [2][1024];

    int n_ops;
    logic op_wr [512];
    logic [15:0] op_addr [512];
    logic [2:0] op_size [512];
    logic [31:0] op_wd [512];
    logic [31:0] res_data [512];
    logic res_resp [512];
    logic res_e1 [512];
    int res_wait [512];

    always #5 clk = ~clk;

    peripheral_spram_ahb3_ws #(.PLEN(16), .XLEN(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
        .HRDATA(hrdata[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011),
        .HTRANS(htrans[0]), .HMASTLOCK(1'b0), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]));

    peripheral_spram_ahb3_ws #(.PLEN(16), .XLEN(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
        .HRDATA(hrdata[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b000), .HPROT(4'b0011),
        .HTRANS(htrans[1]), .HMASTLOCK(1'b0), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]));

    task automatic add_op(input logic wr, input logic [15:0] a, input logic [2:0] s, input logic [31:0] wd);
        op_wr[n_ops] = wr;
        op_addr[n_ops] = a;
        op_size[n_ops] = s;
        op_wd[n_ops] = wd;
        n_ops++;
    endtask

    // Pipelined master: next address phase rides on the cycle that completes the current data phase.
    task automatic run(input int d);
        int ia = 0;
        int dp = -1;
        int cyc = 0;
        while ((ia < n_ops || dp >= 0) && cyc < 20000) begin
            if (ia < n_ops) begin
                hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = op_addr[ia];
                hwrite[d] = op_wr[ia]; hsize[d] = op_size[ia];
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hwdata[d] = (dp >= 0 && op_wr[dp]) ? op_wd[dp] : 32'h0;
            @(negedge clk);
            if (dp >= 0) begin
                if (!hreadyout[d]) begin
                    res_wait[dp]++;
                    res_e1[dp] = res_e1[dp] | hresp[d];
                end else begin
                    res_data[dp] = hrdata[d];
                    res_resp[dp] = hresp[d];
                end
            end
            if (hreadyout[d]) begin
                if (ia < n_ops) begin
                    dp = ia; res_wait[ia] = 0; res_e1[ia] = 1'b0; ia++;
                end else dp = -1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = 32'h0;
        if (cyc >= 20000) begin
            checks++; fails++;
            $display("FAIL run_timeout dut%0d: %0d cycles, required completion", d, cyc);
        end
    endtask

    task automatic check_ops(input int d);
        for (int i = 0; i < n_ops; i++) begin
            int a = int'(op_addr[i]);
            int sz = int'(op_size[i]);
            logic legal = (a < 1024) && (sz <= 2) && ((a % (1 << sz)) == 0);
            int exp_wait = !legal ? 1 : op_wr[i] ? 0 : ws[d];
            logic [31:0] exp;
            checks++;
            if (res_wait[i] !== exp_wait) begin
                fails++;
                $display("FAIL wait dut%0d op%0d addr=%h: got %0d exp %0d", d, i, a, res_wait[i], exp_wait);
            end
            checks++;
            if (res_resp[i] !== !legal || res_e1[i] !== !legal) begin
                fails++;
                $display("FAIL resp dut%0d op%0d addr=%h: got final=%b err1=%b exp %b", d, i, a, res_resp[i], res_e1[i], !legal);
            end
            if (legal && op_wr[i]) begin
                for (int k = 0; k < (1 << sz); k++) mm[d][a+k] = op_wd[i][8*((a+k)%4) +: 8];
            end else if (legal) begin
                int w = a & ~3;
                exp = {mm[d][w+3], mm[d][w+2], mm[d][w+1], mm[d][w]};
                checks++;
                if (res_data[i] !== exp) begin
                    fails++;
                    $display("FAIL rdata dut%0d op%0d addr=%h: got %h exp %h", d, i, a, res_data[i], exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h exp 1 0 0", d, hreadyout[d], hresp[d], hrdata[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        for (int d = 0; d < 2; d++) begin
            n_ops = 0;
            add_op(1, 16'h0010, 3'd2, 32'hDEADBEEF);
            add_op(0, 16'h0010, 3'd2, 32'h0);
            add_op(1, 16'h0011, 3'd0, 32'h0000A500);
            add_op(0, 16'h0010, 3'd2, 32'h0);
            add_op(1, 16'h0020, 3'd2, 32'h12345678);
            add_op(0, 16'h0020, 3'd2, 32'h0);
            add_op(0, 16'h0400, 3'd2, 32'h0);
            add_op(0, 16'h0013, 3'd1, 32'h0);
            add_op(1, 16'h0012, 3'd2, 32'hFFFFFFFF);
            add_op(0, 16'h0010, 3'd2, 32'h0);
            run(d);
            check_ops(d);
            checks++;
            if (res_data[1] !== 32'hDEADBEEF || res_data[3] !== 32'hDEADA5EF || res_data[9] !== 32'hDEADA5EF) begin
                fails++;
                $display("FAIL directed_data dut%0d: got %h %h %h exp deadbeef deada5ef deada5ef", d, res_data[1], res_data[3], res_data[9]);
            end
            checks++;
            if (res_data[5] !== 32'h12345678) begin
                fails++;
                $display("FAIL forward dut%0d: got %h exp 12345678", d, res_data[5]);
            end
            if (d == 0) begin
                checks++;
                if (res_wait[4] !== 0 || res_wait[5] !== 0 || res_wait[1] !== 0) begin
                    fails++;
                    $display("FAIL zero_wait dut0: got waits %0d %0d %0d exp 0 0 0", res_wait[1], res_wait[4], res_wait[5]);
                end
            end
            checks++;
            if (res_resp[6] !== 1'b1 || res_wait[6] !== 1 || res_resp[7] !== 1'b1 || res_wait[7] !== 1) begin
                fails++;
                $display("FAIL error_resp dut%0d: got resp %b/%b waits %0d/%0d exp 1/1 1/1", d, res_resp[6], res_resp[7], res_wait[6], res_wait[7]);
            end
        end
    endtask

    task automatic test_wait_states();
        n_ops = 0;
        add_op(0, 16'h0010, 3'd2, 32'h0);
        run(1);
        check_ops(1);
        checks++;
        if (res_wait[0] !== 3 || res_data[0] !== 32'hDEADA5EF || res_resp[0] !== 1'b0) begin
            fails++;
            $display("FAIL wait3_read: got waits=%0d data=%h resp=%b exp 3 deada5ef 0", res_wait[0], res_data[0], res_resp[0]);
        end
    endtask

    task automatic test_reset_abort();
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 16'h0010; hwrite[1] = 1'b0; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        @(negedge clk);
        checks++;
        if (hreadyout[1] !== 1'b0) begin
            fails++;
            $display("FAIL abort_in_wait: got ready=%b exp 0", hreadyout[1]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hreadyout[1] !== 1'b1 || hresp[1] !== 1'b0 || hrdata[1] !== 32'h0) begin
            fails++;
            $display("FAIL abort_after_reset: got ready=%b resp=%b rdata=%h exp 1 0 0", hreadyout[1], hresp[1], hrdata[1]);
        end
        @(posedge clk); #1;
        n_ops = 0;
        add_op(0, 16'h0010, 3'd2, 32'h0);
        run(1);
        check_ops(1);
        checks++;
        if (res_data[0] !== 32'hDEADA5EF) begin
            fails++;
            $display("FAIL read_after_abort: got %h exp deada5ef", res_data[0]);
        end
    endtask

    task automatic test_fill();
        for (int d = 0; d < 2; d++) begin
            n_ops = 0;
            for (int i = 0; i < 256; i++) add_op(1, 16'(i * 4), 3'd2, $urandom);
            run(d);
            check_ops(d);
        end
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            n_ops = 0;
            for (int i = 0; i < 150; i++) begin
                int r = $urandom_range(0, 9);
                int sz = (r < 3) ? 0 : (r < 5) ? 1 : (r < 9) ? 2 : 3;
                int a = $urandom_range(0, 1100);
                if ($urandom_range(0, 9) < 8) a = a & ~((1 << sz) - 1);
                add_op(1'($urandom_range(0, 1)), 16'(a), 3'(sz), $urandom);
            end
            run(d);
            check_ops(d);
        end
    endtask

`ifdef PERIPHERAL_SPRAM_AHB3_PARITY_EN
    task automatic test_parity();
        repeat (2) @(posedge clk);
        #1;
        u_dut0.r_mem[4] = u_dut0.r_mem[4] ^ 32'h0000_0001;
        n_ops = 0;
        add_op(0, 16'h0010, 3'd2, 32'h0);
        add_op(0, 16'h0013, 3'd0, 32'h0);
        run(0);
        checks++;
        if (res_resp[0] !== 1'b1 || res_e1[0] !== 1'b1 || res_wait[0] !== 1) begin
            fails++;
            $display("FAIL parity_error: got resp=%b err1=%b waits=%0d exp 1 1 1", res_resp[0], res_e1[0], res_wait[0]);
        end
        checks++;
        if (res_resp[1] !== 1'b0 || res_wait[1] !== 0) begin
            fails++;
            $display("FAIL parity_other_lane: got resp=%b waits=%0d exp 0 0", res_resp[1], res_wait[1]);
        end
    endtask
`endif

    initial begin
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = '0; hwdata[d] = '0; hwrite[d] = 1'b0; hsize[d] = 3'd2; htrans[d] = 2'b00;
        end
        test_reset();
        test_directed();
        test_wait_states();
        test_reset_abort();
        test_fill();
        test_random();
`ifdef PERIPHERAL_SPRAM_AHB3_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
